debug_slave_sysclk_bridge: RTL and testbench
============================================

DEBUG_SLAVE_SYSCLK_BRIDGE -- requirements
Module: debug_slave_sysclk_bridge

Interface
REQ-001 SHALL have parameter IR_WIDTH, default 2, meaning instruction-register width; channel count NUM_CH = 2**IR_WIDTH.
REQ-002 SHALL have parameter DR_WIDTH, default 38, meaning data-register and jdo width.
REQ-003 SHALL have parameter ACT_BIT, default 34, meaning the jdo bit selecting action (1) or no-action (0); legal range 0..DR_WIDTH-1.
REQ-004 SHALL have parameter SYNC_STAGES, default 2, minimum 2, meaning synchroniser depth for vs_uir/vs_udr.
REQ-005 SHALL have parameter TIMEOUT, default 255, minimum 1, meaning the maximum number of clk cycles spent waiting for action_ready.
REQ-006 SHALL have port clk, input, 1 bit, the single system clock; all logic sits on its rising edge.
REQ-007 SHALL have port reset_n, input, 1 bit; one clock, reset is synchronous and active-low.
REQ-008 SHALL have port vs_uir, input, 1 bit, JTAG-domain update-IR level (asynchronous to clk).
REQ-009 SHALL have port vs_udr, input, 1 bit, JTAG-domain update-DR level (asynchronous to clk).
REQ-010 SHALL have port ir_in, input, IR_WIDTH bits, JTAG instruction, stable while vs_uir is high.
REQ-011 SHALL have port sr, input, DR_WIDTH bits, JTAG shift register, stable while vs_udr is high.
REQ-012 SHALL have port action_ready, input, NUM_CH bits, per-channel consumer ready.
REQ-013 SHALL have port clr_err, input, 1 bit, which clears the sticky error flags.
REQ-014 SHALL have port jdo, output, DR_WIDTH bits, the captured DR contents.
REQ-015 SHALL have port take_action, output, NUM_CH bits, one-cycle per-channel action strobe.
REQ-016 SHALL have port take_no_action, output, NUM_CH bits, one-cycle per-channel no-action strobe.
REQ-017 SHALL have port busy, output, 1 bit, high when the FSM is not IDLE.
REQ-018 SHALL have port overrun, output, 1 bit, sticky flag: an update-DR arrived while busy.
REQ-019 SHALL have port timeout_err, output, 1 bit, sticky flag: a command was dropped after TIMEOUT.
REQ-020 SHALL have port cmd_count, output, 16 bits, the count of issued take_action strobes.

Function
REQ-021 SHALL pass vs_uir and vs_udr through separate SYNC_STAGES-flop synchronisers and generate rising-edge pulses uir_p and udr_p, each one cycle wide.
REQ-022 SHALL raise udr_p in the cycle following the SYNC_STAGES-th edge after vs_udr is first sampled high; a level held high SHALL yield exactly one pulse.
REQ-023 SHALL load ir_in into internal ir_reg on uir_p.
REQ-024 SHALL use the new ir_reg value for a capture when uir_p and udr_p occur in the same cycle.
REQ-025 SHALL implement FSM states IDLE and ISSUE.
REQ-026 In IDLE, on udr_p, SHALL load jdo <= sr, latch ch <= ir_reg, clear the wait counter, and go to ISSUE.
REQ-027 In ISSUE with jdo[ACT_BIT]=0, SHALL assert take_no_action[ch] for one cycle (action_ready is ignored), then go to IDLE.
REQ-028 In ISSUE with jdo[ACT_BIT]=1 and action_ready[ch]=1, SHALL assert take_action[ch] for one cycle, increment cmd_count (modulo 2^16, wrapping 0xFFFF->0x0000), then go to IDLE.
REQ-029 In ISSUE with jdo[ACT_BIT]=1 and action_ready[ch]=0, SHALL increment the wait counter and remain in ISSUE.
REQ-030 SHALL set timeout_err, go to IDLE and issue no strobe when the wait counter reaches TIMEOUT.
REQ-031 Strobes SHALL be decoded combinationally from the registered state, so a strobe is high in the cycle immediately after the capture edge when ready.
REQ-032 SHALL assert at most one bit of take_action|take_no_action in any cycle.
REQ-033 On udr_p while in ISSUE, SHALL set overrun and leave jdo, ch and the FSM unchanged (the new command is dropped).
REQ-034 SHALL clear overrun and timeout_err on clr_err; if clr_err coincides with a set event, the set wins.
REQ-035 jdo SHALL hold its value between captures.

Reset
REQ-036 While reset_n=0 at a clk edge, SHALL clear all synchroniser flops, ir_reg, ch, jdo, the wait counter, cmd_count, overrun and timeout_err, and set the FSM to IDLE.
REQ-037 During reset, take_action=0, take_no_action=0 and busy=0.
REQ-038 Reset asserted mid-ISSUE SHALL abort the command with no strobe; after release, a vs_udr level still high SHALL NOT generate udr_p until it has been seen low.

Verification
REQ-039 With uir carrying ir_in=2, then udr carrying sr bit34=1 and action_ready=4'b0100 -> jdo=sr, take_action=4'b0100 for one cycle, 3 edges after vs_udr is sampled, cmd_count=1.
REQ-040 With ir=1, sr bit34=0 and action_ready=0 -> take_no_action=4'b0010 for one cycle, cmd_count unchanged.
REQ-041 With TIMEOUT=4, ir=3, bit34=1 and action_ready held 0 -> busy for 4 cycles, no strobe, timeout_err=1; clr_err then clears timeout_err to 0.
REQ-042 A second vs_udr pulse while stalled in ISSUE -> overrun=1, jdo unchanged; action_ready then rises -> the original command's take_action fires.
REQ-043 With cmd_count preloaded via 65535 issued actions, one more action -> cmd_count=0x0000.
REQ-044 reset_n=0 during ISSUE with vs_udr held high -> all outputs 0 and no udr_p after release until vs_udr toggles low and then high.

Source files
------------

// File: rtl/debug_slave_sysclk_bridge.sv
// debug_slave_sysclk_bridge: carries JTAG update-IR/update-DR events into clk and issues per-channel command strobes
//   clk, reset_n             system clock, synchronous active-low reset
//   vs_uir, vs_udr           asynchronous JTAG update-IR / update-DR levels
//   ir_in, sr                JTAG instruction and shift register contents
//   action_ready             per-channel consumer ready
//   clr_err                  clears overrun and timeout_err
//   jdo                      captured DR contents
//   take_action/no_action    one-cycle per-channel strobes
//   busy, overrun,
//   timeout_err, cmd_count   status
module debug_slave_sysclk_bridge #(
    parameter int IR_WIDTH    = 2,
    parameter int DR_WIDTH    = 38,
    parameter int ACT_BIT     = 34,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   vs_uir,
    input  logic                   vs_udr,
    input  logic [IR_WIDTH-1:0]    ir_in,
    input  logic [DR_WIDTH-1:0]    sr,
    input  logic [2**IR_WIDTH-1:0] action_ready,
    input  logic                   clr_err,
    output logic [DR_WIDTH-1:0]    jdo,
    output logic [2**IR_WIDTH-1:0] take_action,
    output logic [2**IR_WIDTH-1:0] take_no_action,
    output logic                   busy,
    output logic                   overrun,
    output logic                   timeout_err,
    output logic [15:0]            cmd_count
);
    localparam int NUM_CH = 2**IR_WIDTH;
    localparam int WW     = $clog2(TIMEOUT + 1);
    localparam int S      = SYNC_STAGES;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t              state_q, state_d;
    logic [S-1:0]        uir_sync_q, uir_sync_d, udr_sync_q, udr_sync_d, fill_q, fill_d;
    logic                uir_prev_q, uir_prev_d, udr_prev_q, udr_prev_d;
    logic                uir_arm_q, uir_arm_d, udr_arm_q, udr_arm_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d, ch_q, ch_d;
    logic [DR_WIDTH-1:0] jdo_q, jdo_d;
    logic [WW-1:0]       wait_q, wait_d;
    logic [15:0]         cmd_count_q, cmd_count_d;
    logic                overrun_q, overrun_d, timeout_err_q, timeout_err_d;
    logic                uir_p, udr_p, sync_ok;
    logic [NUM_CH-1:0]   act, no_act;

    // fill_q marks when the synchroniser outputs carry post-reset samples; an
    // edge detector only arms once its level has been seen low, so a level
    // still high across reset never yields a pulse
    always_comb begin
        fill_d     = {fill_q[S-2:0], 1'b1};
        sync_ok    = fill_q[S-1];
        uir_sync_d = {uir_sync_q[S-2:0], vs_uir};
        udr_sync_d = {udr_sync_q[S-2:0], vs_udr};
        uir_prev_d = uir_sync_q[S-1];
        udr_prev_d = udr_sync_q[S-1];
        uir_arm_d  = uir_arm_q | (sync_ok & ~uir_sync_q[S-1]);
        udr_arm_d  = udr_arm_q | (sync_ok & ~udr_sync_q[S-1]);
        uir_p      = uir_arm_q & uir_sync_q[S-1] & ~uir_prev_q;
        udr_p      = udr_arm_q & udr_sync_q[S-1] & ~udr_prev_q;
        ir_d       = uir_p ? ir_in : ir_q;
    end

    always_comb begin
        state_d       = state_q;
        jdo_d         = jdo_q;
        ch_d          = ch_q;
        wait_d        = wait_q;
        cmd_count_d   = cmd_count_q;
        overrun_d     = overrun_q & ~clr_err;
        timeout_err_d = timeout_err_q & ~clr_err;
        act           = '0;
        no_act        = '0;
        if (state_q == IDLE) begin
            if (udr_p) begin
                jdo_d   = sr;
                ch_d    = ir_d;
                wait_d  = '0;
                state_d = ISSUE;
            end
        end else begin
            if (udr_p) overrun_d = 1'b1;
            if (!jdo_q[ACT_BIT]) begin
                no_act[ch_q] = 1'b1;
                state_d      = IDLE;
            end else if (action_ready[ch_q]) begin
                act[ch_q]   = 1'b1;
                cmd_count_d = cmd_count_q + 16'd1;
                state_d     = IDLE;
            end else if (wait_q == WW'(TIMEOUT - 1)) begin
                timeout_err_d = 1'b1;
                state_d       = IDLE;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end
    end

    // outputs are gated by reset_n so nothing fires while reset is held
    assign take_action    = reset_n ? act : '0;
    assign take_no_action = reset_n ? no_act : '0;
    assign busy           = reset_n & (state_q == ISSUE);
    assign jdo            = jdo_q;
    assign overrun        = overrun_q;
    assign timeout_err    = timeout_err_q;
    assign cmd_count      = cmd_count_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            fill_q        <= '0;
            uir_sync_q    <= '0;
            udr_sync_q    <= '0;
            uir_prev_q    <= 1'b0;
            udr_prev_q    <= 1'b0;
            uir_arm_q     <= 1'b0;
            udr_arm_q     <= 1'b0;
            ir_q          <= '0;
            ch_q          <= '0;
            jdo_q         <= '0;
            wait_q        <= '0;
            cmd_count_q   <= '0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fill_q        <= fill_d;
            uir_sync_q    <= uir_sync_d;
            udr_sync_q    <= udr_sync_d;
            uir_prev_q    <= uir_prev_d;
            udr_prev_q    <= udr_prev_d;
            uir_arm_q     <= uir_arm_d;
            udr_arm_q     <= udr_arm_d;
            ir_q          <= ir_d;
            ch_q          <= ch_d;
            jdo_q         <= jdo_d;
            wait_q        <= wait_d;
            cmd_count_q   <= cmd_count_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
        end
    end
endmodule

// File: tb/tb_debug_slave_sysclk_bridge.sv
// tb_debug_slave_sysclk_bridge: directed self-checking bench for debug_slave_sysclk_bridge
module tb_debug_slave_sysclk_bridge;
    localparam logic [37:0] SR_A  = 38'h05DEADBEEF;
    localparam logic [37:0] SR_N  = 38'h3B00001111;
    localparam logic [37:0] SR_T  = 38'h04000000AA;
    localparam logic [37:0] SR_O1 = 38'h0511112222;
    localparam logic [37:0] SR_O2 = 38'h0433334444;

    logic        clk = 1'b0, reset_n = 1'b0, vs_uir = 1'b0, vs_udr = 1'b0, clr_err = 1'b0;
    logic [1:0]  ir_in = '0;
    logic [37:0] sr = '0;
    logic [3:0]  action_ready = '0;
    logic [37:0] jdo;
    logic [3:0]  take_action, take_no_action;
    logic        busy, overrun, timeout_err;
    logic [15:0] cmd_count;
    int          vectors = 0, miscompares = 0;

    debug_slave_sysclk_bridge #(.TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n), .vs_uir(vs_uir), .vs_udr(vs_udr), .ir_in(ir_in), .sr(sr),
        .action_ready(action_ready), .clr_err(clr_err), .jdo(jdo), .take_action(take_action),
        .take_no_action(take_no_action), .busy(busy), .overrun(overrun), .timeout_err(timeout_err),
        .cmd_count(cmd_count)
    );

    always #5 clk = ~clk;

    task automatic do_uir(input logic [1:0] ir);
        @(negedge clk);
        ir_in = ir;
        vs_uir = 1'b1;
        repeat (3) @(negedge clk);
        vs_uir = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++; if (take_action !== 4'b0) begin miscompares++; $display("FAIL rst_act got %b want 0000", take_action); end
        vectors++; if (take_no_action !== 4'b0) begin miscompares++; $display("FAIL rst_noact got %b want 0000", take_no_action); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
        vectors++; if (jdo !== 38'h0) begin miscompares++; $display("FAIL rst_jdo got %h want 0", jdo); end
        vectors++; if (cmd_count !== 16'h0) begin miscompares++; $display("FAIL rst_cnt got %h want 0", cmd_count); end
        vectors++; if ({overrun, timeout_err} !== 2'b00) begin miscompares++; $display("FAIL rst_err got %b want 00", {overrun, timeout_err}); end
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_action();
        do_uir(2'd2);
        action_ready = 4'b0100;
        sr = SR_A;
        vs_udr = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (take_action !== 4'b0) begin miscompares++; $display("FAIL act_early got %b want 0000", take_action); end
        @(negedge clk);
        vectors++; if (take_action !== 4'b0100) begin miscompares++; $display("FAIL act_strobe got %b want 0100", take_action); end
        vectors++; if (take_no_action !== 4'b0) begin miscompares++; $display("FAIL act_noact got %b want 0000", take_no_action); end
        vectors++; if (jdo !== SR_A) begin miscompares++; $display("FAIL act_jdo got %h want %h", jdo, SR_A); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL act_busy got %b want 1", busy); end
        @(negedge clk);
        vectors++; if (take_action !== 4'b0) begin miscompares++; $display("FAIL act_oneshot got %b want 0000", take_action); end
        vectors++; if (cmd_count !== 16'd1) begin miscompares++; $display("FAIL act_cnt got %0d want 1", cmd_count); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL act_idle got %b want 0", busy); end
        repeat (4) @(negedge clk);
        vectors++; if (take_action !== 4'b0) begin miscompares++; $display("FAIL act_level got %b want 0000", take_action); end
        vs_udr = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_no_action();
        do_uir(2'd1);
        action_ready = 4'b0;
        sr = SR_N;
        vs_udr = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (take_no_action !== 4'b0010) begin miscompares++; $display("FAIL noact_strobe got %b want 0010", take_no_action); end
        vectors++; if (take_action !== 4'b0) begin miscompares++; $display("FAIL noact_act got %b want 0000", take_action); end
        @(negedge clk);
        vectors++; if (take_no_action !== 4'b0) begin miscompares++; $display("FAIL noact_oneshot got %b want 0000", take_no_action); end
        vectors++; if (cmd_count !== 16'd1) begin miscompares++; $display("FAIL noact_cnt got %0d want 1", cmd_count); end
        vs_udr = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_timeout();
        int nb, ns;
        do_uir(2'd3);
        action_ready = 4'b0;
        sr = SR_T;
        vs_udr = 1'b1;
        repeat (3) @(negedge clk);
        nb = 0;
        ns = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy) nb++;
            if ((take_action | take_no_action) != 4'b0) ns++;
            @(negedge clk);
        end
        vectors++; if (nb !== 4) begin miscompares++; $display("FAIL to_busy got %0d cycles want 4", nb); end
        vectors++; if (ns !== 0) begin miscompares++; $display("FAIL to_strobe got %0d want 0", ns); end
        vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL to_flag got %b want 1", timeout_err); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL to_ovr got %b want 0", overrun); end
        vs_udr = 1'b0;
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL to_clr got %b want 0", timeout_err); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_overrun();
        do_uir(2'd0);
        action_ready = 4'b0;
        sr = SR_O1;
        vs_udr = 1'b1;
        @(negedge clk);
        vs_udr = 1'b0;
        repeat (2) @(negedge clk);
        sr = SR_O2;
        vs_udr = 1'b1;
        @(negedge clk);
        vs_udr = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_flag got %b want 1", overrun); end
        vectors++; if (jdo !== SR_O1) begin miscompares++; $display("FAIL ovr_jdo got %h want %h", jdo, SR_O1); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ovr_busy got %b want 1", busy); end
        vectors++; if (take_action !== 4'b0) begin miscompares++; $display("FAIL ovr_stall got %b want 0000", take_action); end
        action_ready = 4'b0001;
        #1;
        vectors++; if (take_action !== 4'b0001) begin miscompares++; $display("FAIL ovr_fire got %b want 0001", take_action); end
        @(negedge clk);
        vectors++; if (take_action !== 4'b0) begin miscompares++; $display("FAIL ovr_oneshot got %b want 0000", take_action); end
        vectors++; if (cmd_count !== 16'd2) begin miscompares++; $display("FAIL ovr_cnt got %0d want 2", cmd_count); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ovr_idle got %b want 0", busy); end
        action_ready = 4'b0;
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_clr got %b want 0", overrun); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n, bad;
        do_uir(2'd2);
        action_ready = 4'b0100;
        sr = SR_A;
        n = 0;
        bad = 0;
        for (int i = 0; i < 26; i++) begin
            if (take_action == 4'b0100) n++;
            else if ((take_action | take_no_action) != 4'b0) bad++;
            vs_udr = (i < 20) && (i % 2 == 0);
            @(negedge clk);
        end
        vectors++; if (n !== 10) begin miscompares++; $display("FAIL b2b_count got %0d strobes want 10", n); end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL b2b_stray got %0d want 0", bad); end
        vectors++; if (cmd_count !== 16'd12) begin miscompares++; $display("FAIL b2b_cnt got %0d want 12", cmd_count); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL b2b_ovr got %b want 0", overrun); end
    endtask

    task automatic test_same_cycle();
        @(negedge clk);
        ir_in = 2'd3;
        sr = SR_N;
        vs_uir = 1'b1;
        vs_udr = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (take_no_action !== 4'b1000) begin miscompares++; $display("FAIL same_ch got %b want 1000", take_no_action); end
        vs_uir = 1'b0;
        vs_udr = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.cmd_count_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.cmd_count_q;
        @(negedge clk);
        vectors++; if (cmd_count !== 16'hFFFF) begin miscompares++; $display("FAIL wrap_pre got %h want ffff", cmd_count); end
        do_uir(2'd2);
        action_ready = 4'b0100;
        sr = SR_A;
        vs_udr = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (take_action !== 4'b0100) begin miscompares++; $display("FAIL wrap_fire got %b want 0100", take_action); end
        @(negedge clk);
        vectors++; if (cmd_count !== 16'h0000) begin miscompares++; $display("FAIL wrap_cnt got %h want 0000", cmd_count); end
        vs_udr = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_issue();
        int nb, ns;
        do_uir(2'd1);
        action_ready = 4'b0;
        sr = SR_T;
        vs_udr = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rmid_busy got %b want 1", busy); end
        reset_n = 1'b0;
        #1;
        vectors++; if ({busy, take_action, take_no_action} !== 9'b0) begin miscompares++; $display("FAIL rmid_gate got %b want 0", {busy, take_action, take_no_action}); end
        repeat (2) @(negedge clk);
        vectors++; if (jdo !== 38'h0) begin miscompares++; $display("FAIL rmid_jdo got %h want 0", jdo); end
        vectors++; if ({cmd_count, overrun, timeout_err} !== 18'h0) begin miscompares++; $display("FAIL rmid_state got %h want 0", {cmd_count, overrun, timeout_err}); end
        reset_n = 1'b1;
        nb = 0;
        ns = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if ((take_action | take_no_action) != 4'b0) ns++;
        end
        vectors++; if (nb + ns !== 0) begin miscompares++; $display("FAIL rmid_nopulse got %0d want 0", nb + ns); end
        vs_udr = 1'b0;
        sr = SR_N;
        repeat (4) @(negedge clk);
        vs_udr = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (take_no_action !== 4'b0001) begin miscompares++; $display("FAIL rmid_rearm got %b want 0001", take_no_action); end
        @(negedge clk);
        vectors++; if (take_no_action !== 4'b0) begin miscompares++; $display("FAIL rmid_oneshot got %b want 0000", take_no_action); end
        vs_udr = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_action();
        test_no_action();
        test_timeout();
        test_overrun();
        test_back_to_back();
        test_same_cycle();
        test_wrap();
        test_reset_mid_issue();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
